// File: rtl/mnist_frame_streamer.sv
// Frame buffer and replay engine in front of MNIST_MLP: loads one 28x28 frame over valid/ready,
// replays it as a gap-free burst plus pad pixel, then captures the class. Option: MNIST_STREAM_THRESH_EN.
module mnist_frame_streamer #(
   parameter int         NUM_PIXELS     = 784,
   parameter logic [7:0] PAD_PIXEL      = 8'hFF,
   parameter int         TIMEOUT_CYCLES = 65535,
   parameter logic [7:0] THRESH         = 8'd32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       s_valid,
   input  logic [7:0] s_data,
   output logic       s_ready,
   output logic       mlp_input_en,
   output logic [7:0] mlp_pixel,
   input  logic       mlp_output_en,
   input  logic [3:0] mlp_index,
   output logic       result_valid,
   output logic [3:0] result_index,
   output logic       result_timeout,
   output logic       busy
);

   localparam int CNT_W = $clog2(NUM_PIXELS + 1);
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PIXELS - 1);
   localparam logic [CNT_W-1:0] END_IDX  = CNT_W'(NUM_PIXELS);
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {ST_LOAD, ST_STREAM, ST_PAD, ST_WAIT} state_t;

   state_t           state_q, state_d;
   logic             s_ready_q, s_ready_d;
   logic             mlp_input_en_q, mlp_input_en_d;
   logic [7:0]       mlp_pixel_q, mlp_pixel_d;
   logic             result_valid_q, result_valid_d;
   logic [3:0]       result_index_q, result_index_d;
   logic             result_timeout_q, result_timeout_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic [TO_W-1:0]  to_next;
   logic             wr_en;
   logic             beat;
   logic [7:0]       wr_data;
   logic [7:0]       frame_mem [NUM_PIXELS];

`ifdef MNIST_STREAM_THRESH_EN
   assign wr_data = (s_data >= THRESH) ? 8'hFF : 8'h00;
`else
   logic [7:0] unused_thresh;
   assign unused_thresh = THRESH;
   assign wr_data       = s_data;
`endif

   assign beat    = s_valid & s_ready_q;
   assign to_next = to_cnt_q + 1'b1;

   // NOTE: every signal gets its hold value first, so no path through the case can infer a latch.
   always_comb begin
      state_d          = state_q;
      s_ready_d        = s_ready_q;
      mlp_input_en_d   = mlp_input_en_q;
      mlp_pixel_d      = mlp_pixel_q;
      result_valid_d   = result_valid_q;
      result_index_d   = result_index_q;
      result_timeout_d = result_timeout_q;
      busy_d           = busy_q;
      wr_cnt_d         = wr_cnt_q;
      rd_cnt_d         = rd_cnt_q;
      to_cnt_d         = to_cnt_q;
      wr_en            = 1'b0;
      unique case (state_q)
         ST_LOAD: begin
            if (beat) begin
               wr_en    = 1'b1;
               wr_cnt_d = wr_cnt_q + 1'b1;
               if (wr_cnt_q == '0) begin
                  result_valid_d   = 1'b0;
                  result_timeout_d = 1'b0;
               end
               if (wr_cnt_q == LAST_IDX) begin
                  // Pixel 0 goes out on the very next cycle, so it is fetched while the last beat lands.
                  state_d        = ST_STREAM;
                  s_ready_d      = 1'b0;
                  busy_d         = 1'b1;
                  mlp_input_en_d = 1'b1;
                  mlp_pixel_d    = (LAST_IDX == '0) ? wr_data : frame_mem[0];
                  rd_cnt_d       = CNT_W'(1);
                  wr_cnt_d       = '0;
               end
            end
         end
         ST_STREAM: begin
            if (rd_cnt_q == END_IDX) begin
               state_d     = ST_PAD;
               mlp_pixel_d = PAD_PIXEL;
            end else begin
               mlp_pixel_d = frame_mem[rd_cnt_q];
               rd_cnt_d    = rd_cnt_q + 1'b1;
            end
         end
         ST_PAD: begin
            state_d        = ST_WAIT;
            mlp_input_en_d = 1'b0;
            rd_cnt_d       = '0;
            to_cnt_d       = TO_W'(1);
         end
         ST_WAIT: begin
            // A real answer beats a timeout expiring in the same cycle.
            if (mlp_output_en) begin
               result_valid_d   = 1'b1;
               result_index_d   = mlp_index;
               result_timeout_d = 1'b0;
            end else if (to_next >= TO_LIMIT) begin
               result_valid_d   = 1'b1;
               result_index_d   = 4'hF;
               result_timeout_d = 1'b1;
            end else begin
               to_cnt_d = to_next;
            end
            if (mlp_output_en || to_next >= TO_LIMIT) begin
               state_d   = ST_LOAD;
               s_ready_d = 1'b1;
               busy_d    = 1'b0;
               wr_cnt_d  = '0;
               to_cnt_d  = '0;
            end
         end
         default: state_d = ST_LOAD;
      endcase
   end

   // NOTE: the frame buffer has no reset; every location is written before it is replayed.
   always_ff @(posedge clk) begin
      if (wr_en) frame_mem[wr_cnt_q] <= wr_data;
   end

   // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= ST_LOAD;
         s_ready_q        <= 1'b1;
         mlp_input_en_q   <= 1'b0;
         mlp_pixel_q      <= 8'h00;
         result_valid_q   <= 1'b0;
         result_index_q   <= 4'h0;
         result_timeout_q <= 1'b0;
         busy_q           <= 1'b0;
         wr_cnt_q         <= '0;
         rd_cnt_q         <= '0;
         to_cnt_q         <= '0;
      end else begin
         state_q          <= state_d;
         s_ready_q        <= s_ready_d;
         mlp_input_en_q   <= mlp_input_en_d;
         mlp_pixel_q      <= mlp_pixel_d;
         result_valid_q   <= result_valid_d;
         result_index_q   <= result_index_d;
         result_timeout_q <= result_timeout_d;
         busy_q           <= busy_d;
         wr_cnt_q         <= wr_cnt_d;
         rd_cnt_q         <= rd_cnt_d;
         to_cnt_q         <= to_cnt_d;
      end
   end

   assign s_ready        = s_ready_q;
   assign mlp_input_en   = mlp_input_en_q;
   assign mlp_pixel      = mlp_pixel_q;
   assign result_valid   = result_valid_q;
   assign result_index   = result_index_q;
   assign result_timeout = result_timeout_q;
   assign busy           = busy_q;

endmodule
